// File: rtl/page_stream_bridge.sv
// Buffered leaf<->kernel stream bridge: one FIFO per channel plus an IDLE/RUN/DRAIN start sequencer.
// Optional per-channel transfer counters are built when PAGE_STREAM_BRIDGE_STATS_EN is defined.

module page_stream_bridge_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
endmodule

module page_stream_bridge #(
    parameter int NUM_IN_PORTS  = 4,
    parameter int NUM_OUT_PORTS = 3,
    parameter int PAYLOAD_BITS  = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    ap_start_in,
    output logic                                    ap_start_kernel,
    output logic                                    kernel_rst_n,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    leaf_in_data,
    input  logic [NUM_IN_PORTS-1:0]                 leaf_in_vld,
    output logic [NUM_IN_PORTS-1:0]                 leaf_in_ack,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    krn_in_tdata,
    output logic [NUM_IN_PORTS-1:0]                 krn_in_tvalid,
    input  logic [NUM_IN_PORTS-1:0]                 krn_in_tready,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   krn_out_tdata,
    input  logic [NUM_OUT_PORTS-1:0]                krn_out_tvalid,
    output logic [NUM_OUT_PORTS-1:0]                krn_out_tready,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   leaf_out_data,
    output logic [NUM_OUT_PORTS-1:0]                leaf_out_vld,
    input  logic [NUM_OUT_PORTS-1:0]                leaf_out_ack,
    output logic [NUM_IN_PORTS*32-1:0]              stat_in_count,
    output logic [NUM_OUT_PORTS*32-1:0]             stat_out_count,
    output logic                                    busy
);
    // Handshake rule on every channel: a word moves in a cycle where both the
    // valid side and the accepting side are high; accept signals depend only on
    // registered occupancy and state, never on the partner's valid.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;

    logic [NUM_IN_PORTS-1:0]  full_in, empty_in, push_in, pop_in;
    logic [NUM_OUT_PORTS-1:0] full_out, empty_out, push_out, pop_out;
    logic in_open, out_open;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            ap_start_kernel <= 1'b0;
            busy            <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (ap_start_in) begin
                    state           <= RUN;
                    ap_start_kernel <= 1'b1;
                    busy            <= 1'b1;
                end
                RUN: if (!ap_start_in) begin
                    state           <= DRAIN;
                    ap_start_kernel <= 1'b0;
                end
                DRAIN: if (ap_start_in) begin
                    state           <= RUN;
                    ap_start_kernel <= 1'b1;
                end else if (&empty_out && !(|krn_out_tvalid)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state           <= IDLE;
                    ap_start_kernel <= 1'b0;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) kernel_rst_n <= 1'b0;
        else       kernel_rst_n <= 1'b1;
    end

    // Leaf input stays closed while reset is held, even though state is already IDLE.
    assign in_open  = (state != DRAIN) && !reset;
    assign out_open = (state != IDLE);

    assign leaf_in_ack    = ~full_in & {NUM_IN_PORTS{in_open}};
    assign krn_in_tvalid  = ~empty_in & {NUM_IN_PORTS{state == RUN}};
    assign krn_out_tready = ~full_out & {NUM_OUT_PORTS{out_open}};
    assign leaf_out_vld   = ~empty_out;

    assign push_in  = leaf_in_vld & leaf_in_ack;
    assign pop_in   = krn_in_tvalid & krn_in_tready;
    assign push_out = krn_out_tvalid & krn_out_tready;
    assign pop_out  = leaf_out_vld & leaf_out_ack;

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
        page_stream_bridge_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push_in[i]),
            .wdata (leaf_in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .pop   (pop_in[i]),
            .rdata (krn_in_tdata[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .full  (full_in[i]),
            .empty (empty_in[i])
        );
    end

    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
        page_stream_bridge_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push_out[j]),
            .wdata (krn_out_tdata[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .pop   (pop_out[j]),
            .rdata (leaf_out_data[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .full  (full_out[j]),
            .empty (empty_out[j])
        );
    end

`ifdef PAGE_STREAM_BRIDGE_STATS_EN
    logic stat_clear;
    assign stat_clear = (state == IDLE) && ap_start_in;

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in_stat
        logic [31:0] cnt;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)          cnt <= '0;
            else if (stat_clear) cnt <= '0;
            else if (pop_in[i])  cnt <= cnt + 32'd1;
        end
        assign stat_in_count[i*32 +: 32] = cnt;
    end

    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out_stat
        logic [31:0] cnt;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)           cnt <= '0;
            else if (stat_clear)  cnt <= '0;
            else if (pop_out[j])  cnt <= cnt + 32'd1;
        end
        assign stat_out_count[j*32 +: 32] = cnt;
    end
`else
    assign stat_in_count  = '0;
    assign stat_out_count = '0;
`endif
endmodule

// File: tb/tb_page_stream_bridge.sv
// Bench for page_stream_bridge: directed scenarios plus random traffic, checked every
// cycle against a queue-based behavioural model of the bridge.
module tb_page_stream_bridge;
  localparam int NI = 4;
  localparam int NO = 3;
  localparam int PB = 32;
  localparam int D  = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ap_start_in = 1'b0;
  logic ap_start_kernel, kernel_rst_n, busy;
  logic [NI*PB-1:0] leaf_in_data = '0;
  logic [NI-1:0] leaf_in_vld = '0;
  logic [NI-1:0] leaf_in_ack;
  logic [NI*PB-1:0] krn_in_tdata;
  logic [NI-1:0] krn_in_tvalid;
  logic [NI-1:0] krn_in_tready = '1;
  logic [NO*PB-1:0] krn_out_tdata = '0;
  logic [NO-1:0] krn_out_tvalid = '0;
  logic [NO-1:0] krn_out_tready;
  logic [NO*PB-1:0] leaf_out_data;
  logic [NO-1:0] leaf_out_vld;
  logic [NO-1:0] leaf_out_ack = '1;
  logic [NI*32-1:0] stat_in_count;
  logic [NO*32-1:0] stat_out_count;

  page_stream_bridge #(
    .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .PAYLOAD_BITS(PB), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset), .ap_start_in(ap_start_in),
    .ap_start_kernel(ap_start_kernel), .kernel_rst_n(kernel_rst_n),
    .leaf_in_data(leaf_in_data), .leaf_in_vld(leaf_in_vld), .leaf_in_ack(leaf_in_ack),
    .krn_in_tdata(krn_in_tdata), .krn_in_tvalid(krn_in_tvalid), .krn_in_tready(krn_in_tready),
    .krn_out_tdata(krn_out_tdata), .krn_out_tvalid(krn_out_tvalid), .krn_out_tready(krn_out_tready),
    .leaf_out_data(leaf_out_data), .leaf_out_vld(leaf_out_vld), .leaf_out_ack(leaf_out_ack),
    .stat_in_count(stat_in_count), .stat_out_count(stat_out_count), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  int checks = 0;
  int fails = 0;
  logic [PB-1:0] in_exp_q [NI][$];
  logic [PB-1:0] out_exp_q [NO][$];
  logic [31:0] m_in_cnt [NI];
  logic [31:0] m_out_cnt [NO];
  int m_state = S_IDLE;
  logic m_krst = 1'b0;
  logic [NI-1:0] ack_e, tv_e;
  logic [NO-1:0] tr_e, vld_e;
  logic go_idle, start_clr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_in_stat(input int i);
`ifdef PAGE_STREAM_BRIDGE_STATS_EN
    return m_in_cnt[i];
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_out_stat(input int j);
`ifdef PAGE_STREAM_BRIDGE_STATS_EN
    return m_out_cnt[j];
`else
    return 32'd0;
`endif
  endfunction

  // monitor: compare at negedge, then advance the model across the coming posedge
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NI; i++) begin in_exp_q[i].delete(); m_in_cnt[i] = '0; end
      for (int j = 0; j < NO; j++) begin out_exp_q[j].delete(); m_out_cnt[j] = '0; end
      m_state = S_IDLE;
      m_krst = 1'b0;
      check("rst_leaf_in_ack", 64'(leaf_in_ack), 64'd0);
      check("rst_krn_in_tvalid", 64'(krn_in_tvalid), 64'd0);
      check("rst_krn_out_tready", 64'(krn_out_tready), 64'd0);
      check("rst_leaf_out_vld", 64'(leaf_out_vld), 64'd0);
      check("rst_ap_start_kernel", 64'(ap_start_kernel), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_kernel_rst_n", 64'(kernel_rst_n), 64'd0);
      check("rst_stat_in", 64'(|stat_in_count), 64'd0);
      check("rst_stat_out", 64'(|stat_out_count), 64'd0);
    end else begin
      check("ap_start_kernel", 64'(ap_start_kernel), 64'(m_state == S_RUN));
      check("busy", 64'(busy), 64'(m_state != S_IDLE));
      check("kernel_rst_n", 64'(kernel_rst_n), 64'(m_krst));
      for (int i = 0; i < NI; i++) begin
        ack_e[i] = (m_state != S_DRAIN) && (in_exp_q[i].size() < D);
        tv_e[i]  = (m_state == S_RUN) && (in_exp_q[i].size() > 0);
      end
      for (int j = 0; j < NO; j++) begin
        tr_e[j]  = (m_state != S_IDLE) && (out_exp_q[j].size() < D);
        vld_e[j] = (out_exp_q[j].size() > 0);
      end
      check("leaf_in_ack", 64'(leaf_in_ack), 64'(ack_e));
      check("krn_in_tvalid", 64'(krn_in_tvalid), 64'(tv_e));
      check("krn_out_tready", 64'(krn_out_tready), 64'(tr_e));
      check("leaf_out_vld", 64'(leaf_out_vld), 64'(vld_e));
      for (int i = 0; i < NI; i++) begin
        if (tv_e[i]) check($sformatf("krn_in_tdata[%0d]", i), 64'(krn_in_tdata[i*PB +: PB]), 64'(in_exp_q[i][0]));
        check($sformatf("stat_in_count[%0d]", i), 64'(stat_in_count[i*32 +: 32]), 64'(exp_in_stat(i)));
      end
      for (int j = 0; j < NO; j++) begin
        if (vld_e[j]) check($sformatf("leaf_out_data[%0d]", j), 64'(leaf_out_data[j*PB +: PB]), 64'(out_exp_q[j][0]));
        check($sformatf("stat_out_count[%0d]", j), 64'(stat_out_count[j*32 +: 32]), 64'(exp_out_stat(j)));
      end

      go_idle = (krn_out_tvalid == '0);
      for (int j = 0; j < NO; j++) if (out_exp_q[j].size() != 0) go_idle = 1'b0;
      start_clr = (m_state == S_IDLE) && ap_start_in;
      for (int i = 0; i < NI; i++) begin
        if (tv_e[i] && krn_in_tready[i]) begin void'(in_exp_q[i].pop_front()); m_in_cnt[i]++; end
        if (ack_e[i] && leaf_in_vld[i]) in_exp_q[i].push_back(leaf_in_data[i*PB +: PB]);
        if (start_clr) m_in_cnt[i] = '0;
      end
      for (int j = 0; j < NO; j++) begin
        if (vld_e[j] && leaf_out_ack[j]) begin void'(out_exp_q[j].pop_front()); m_out_cnt[j]++; end
        if (tr_e[j] && krn_out_tvalid[j]) out_exp_q[j].push_back(krn_out_tdata[j*PB +: PB]);
        if (start_clr) m_out_cnt[j] = '0;
      end
      case (m_state)
        S_IDLE:  if (ap_start_in) m_state = S_RUN;
        S_RUN:   if (!ap_start_in) m_state = S_DRAIN;
        default: if (ap_start_in) m_state = S_RUN; else if (go_idle) m_state = S_IDLE;
      endcase
      m_krst = 1'b1;
    end
  end

  // driver tasks (always called just after a rising edge)
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_in(input int ch, input logic [PB-1:0] d);
    leaf_in_data[ch*PB +: PB] = d;
    leaf_in_vld[ch] = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (leaf_in_ack[ch]) break;
    end
    step(1);
    leaf_in_vld[ch] = 1'b0;
  endtask

  task automatic push_out(input int ch, input logic [PB-1:0] d);
    krn_out_tdata[ch*PB +: PB] = d;
    krn_out_tvalid[ch] = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (krn_out_tready[ch]) break;
    end
    step(1);
    krn_out_tvalid[ch] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(name, 64'(busy), 64'd0);
    step(1);
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    step(2);

    // single word through in-ch0 once started
    ap_start_in = 1'b1;
    step(1);
    push_in(0, 32'hA5A5_0001);
    step(3);

    // backpressure on in-ch1: four words fill the FIFO, the fifth waits
    krn_in_tready[1] = 1'b0;
    for (int w = 1; w <= 4; w++) push_in(1, 32'h1100_0000 + w);
    leaf_in_data[1*PB +: PB] = 32'h1100_0005;
    leaf_in_vld[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_in_ch1_ack_low", 64'(leaf_in_ack[1]), 64'd0);
    end
    step(1);
    krn_in_tready[1] = 1'b1;
    push_in(1, 32'h1100_0005);
    step(6);

    // words buffered while idle are held until start
    ap_start_in = 1'b0;
    wait_idle("wait_idle_before_buffer");
    push_in(2, 32'h2200_0001);
    push_in(2, 32'h2200_0002);
    step(3);
    ap_start_in = 1'b1;
    step(5);

    // drain: three words stuck in out-ch2, then released
    leaf_out_ack = '0;
    for (int w = 1; w <= 3; w++) push_out(2, 32'h3300_0000 + w);
    ap_start_in = 1'b0;
    step(3);
    @(negedge clk);
    check("drain_busy_high", 64'(busy), 64'd1);
    step(1);
    leaf_out_ack = '1;
    wait_idle("wait_idle_after_drain");

    // reset with data buffered on both sides
    ap_start_in = 1'b1;
    leaf_out_ack = '0;
    krn_in_tready = '0;
    step(2);
    push_out(0, 32'h4400_0001);
    push_in(3, 32'h4400_0002);
    step(1);
    reset = 1'b1;
    #1;
    check("async_rst_leaf_out_vld", 64'(leaf_out_vld), 64'd0);
    check("async_rst_krn_in_tvalid", 64'(krn_in_tvalid), 64'd0);
    check("async_rst_kernel_rst_n", 64'(kernel_rst_n), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    step(1);
    reset = 1'b0;
    ap_start_in = 1'b0;
    krn_in_tready = '1;
    leaf_out_ack = '1;
    step(3);

    // random traffic
    ap_start_in = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) leaf_in_data[i*PB +: PB] = $urandom;
      for (int j = 0; j < NO; j++) krn_out_tdata[j*PB +: PB] = $urandom;
      leaf_in_vld    = NI'($urandom_range(0, (1 << NI) - 1));
      krn_in_tready  = NI'($urandom_range(0, (1 << NI) - 1));
      krn_out_tvalid = NO'($urandom_range(0, (1 << NO) - 1));
      leaf_out_ack   = NO'($urandom_range(0, (1 << NO) - 1));
      if ($urandom_range(0, 39) == 0) ap_start_in = ~ap_start_in;
      step(1);
    end

    leaf_in_vld = '0;
    krn_out_tvalid = '0;
    leaf_out_ack = '1;
    krn_in_tready = '1;
    ap_start_in = 1'b0;
    wait_idle("wait_idle_final");
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
